// File: rtl/clk_div_prog.sv
// clk_div_prog -- runtime-programmable integer clock divider.
//
// Produces a registered divided clock o_clk and a one-cycle o_tick strobe
// for any ratio N >= 2, odd or even. Each period has floor(N/2) high cycles
// followed by the remaining low cycles. A new ratio is loaded through a
// valid/ready handshake and takes effect only on a period boundary, so no
// period is ever truncated or merged.
//
// Optional feature macro: CLK_DIV_ODD_50_EN
//   When defined, a falling-edge flop stretches the high phase by half an
//   i_clk cycle for odd N, giving exactly 50% duty. o_tick is unaffected.
//   When undefined, the design uses the rising edge only.
//
// Parameters:
//   P_CNT_WIDTH   - width of the ratio and of the internal counter
//   P_DIV_DEFAULT - ratio in effect after reset (>= 2, < 2**P_CNT_WIDTH)
//
// Ports:
//   i_clk        - clock, all state on the rising edge (see macro above)
//   i_rst        - synchronous active-high reset
//   i_en         - run enable, 0 holds the divider idle with o_clk low
//   i_div        - requested ratio N
//   i_div_valid  - i_div is valid
//   o_div_ready  - a new ratio can be accepted
//   o_cfg_err    - one-cycle pulse after a request with N < 2 is accepted
//   o_div_cur    - ratio currently in effect
//   o_clk        - divided output
//   o_tick       - pulse on the first high cycle of each o_clk period
//
// Handshake: a request transfers on any rising edge where i_div_valid and
// o_div_ready are both 1. i_div is only looked at on that edge. A legal
// ratio is parked as pending and o_div_ready stays low until it is applied;
// an illegal ratio is dropped, o_cfg_err pulses and o_div_ready stays high.
module clk_div_prog #(
  parameter int P_CNT_WIDTH   = 16,
  parameter int P_DIV_DEFAULT = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [P_CNT_WIDTH-1:0] i_div,
  input  logic                   i_div_valid,
  output logic                   o_div_ready,
  output logic                   o_cfg_err,
  output logic [P_CNT_WIDTH-1:0] o_div_cur,
  output logic                   o_clk,
  output logic                   o_tick
);

  localparam logic [P_CNT_WIDTH-1:0] DIV_RST = P_CNT_WIDTH'(P_DIV_DEFAULT);
  localparam logic [P_CNT_WIDTH-1:0] CNT_ONE = P_CNT_WIDTH'(1);
  localparam logic [P_CNT_WIDTH-1:0] DIV_MIN = P_CNT_WIDTH'(2);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // FSM state kept as a named enum so checkers can bind to it directly.
  state_t                 state_q;
  logic [P_CNT_WIDTH-1:0] cnt_q;
  logic [P_CNT_WIDTH-1:0] div_cur_q;
  logic [P_CNT_WIDTH-1:0] div_pend_q;
  logic                   pend_vld_q;
  logic                   clk_q;
  logic                   tick_q;
  logic                   cfg_err_q;

  logic [P_CNT_WIDTH-1:0] half_last;
  logic [P_CNT_WIDTH-1:0] period_last;
  logic                   accept;
  logic                   at_boundary;
  logic                   apply_pend;

  // N >= 2 is guaranteed for div_cur_q, so neither subtraction can wrap.
  assign half_last   = (div_cur_q >> 1) - CNT_ONE;
  assign period_last = div_cur_q - CNT_ONE;

  // Ready is simply "nothing pending", so accept and apply never coincide.
  assign accept      = i_div_valid & ~pend_vld_q;
  assign at_boundary = i_en && (state_q == ST_LOW) && (cnt_q == period_last);

  // In IDLE the pending ratio lands on the next edge regardless of i_en;
  // while running it waits for the LOW->HIGH wrap.
  assign apply_pend  = pend_vld_q && ((state_q == ST_IDLE) || at_boundary);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_cur_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_vld_q <= 1'b0;
      clk_q      <= 1'b0;
      tick_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      tick_q    <= 1'b0;
      cfg_err_q <= 1'b0;

      // Disable has priority over every other transition.
      if (!i_en) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        clk_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_HIGH;
            cnt_q   <= '0;
            clk_q   <= 1'b1;
            tick_q  <= 1'b1;
          end
          ST_HIGH: begin
            cnt_q <= cnt_q + CNT_ONE;
            if (cnt_q == half_last) begin
              state_q <= ST_LOW;
              clk_q   <= 1'b0;
            end
          end
          ST_LOW: begin
            if (cnt_q == period_last) begin
              state_q <= ST_HIGH;
              cnt_q   <= '0;
              clk_q   <= 1'b1;
              tick_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            clk_q   <= 1'b0;
          end
        endcase
      end

      if (apply_pend) begin
        div_cur_q  <= div_pend_q;
        pend_vld_q <= 1'b0;
      end

      if (accept) begin
        if (i_div >= DIV_MIN) begin
          div_pend_q <= i_div;
          pend_vld_q <= 1'b1;
        end else begin
          cfg_err_q <= 1'b1;
        end
      end
    end
  end

`ifdef CLK_DIV_ODD_50_EN
  // Samples the last high cycle of an odd period at the falling edge and
  // holds o_clk high for the first half of the following low cycle.
  logic clk_fall_q;

  always_ff @(negedge i_clk) begin
    if (i_rst) begin
      clk_fall_q <= 1'b0;
    end else begin
      clk_fall_q <= clk_q & div_cur_q[0];
    end
  end

  assign o_clk = clk_q | clk_fall_q;
`else
  assign o_clk = clk_q;
`endif

  assign o_tick      = tick_q;
  assign o_div_ready = ~pend_vld_q;
  assign o_cfg_err   = cfg_err_q;
  assign o_div_cur   = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
`timescale 1ns/100ps
// Self-checking bench for clk_div_prog. A period-position model predicts
// every output once per rising edge; outputs are sampled 6 ns after the
// edge (just past the falling edge) so both builds show the rising-edge view.
module tb_clk_div_prog;

  localparam int W   = 16;
  localparam int DEF = 2;
  localparam int VW  = W + 4;

  logic         i_clk = 1'b0;
  logic         i_rst;
  logic         i_en;
  logic [W-1:0] i_div;
  logic         i_div_valid;
  logic         o_div_ready;
  logic         o_cfg_err;
  logic [W-1:0] o_div_cur;
  logic         o_clk;
  logic         o_tick;

  clk_div_prog #(
    .P_CNT_WIDTH  (W),
    .P_DIV_DEFAULT(DEF)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_en       (i_en),
    .i_div      (i_div),
    .i_div_valid(i_div_valid),
    .o_div_ready(o_div_ready),
    .o_cfg_err  (o_cfg_err),
    .o_div_cur  (o_div_cur),
    .o_clk      (o_clk),
    .o_tick     (o_tick)
  );

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  // ---------------- counters ----------------
  int checks = 0;
  int errors = 0;

  // ---------------- reference model ----------------
  // The divider is described by "running?", "position inside the current
  // period", the ratio in effect and an optional pending ratio.
  bit m_run;
  bit m_pend;
  bit m_err;
  int m_pos;
  int m_cur;
  int m_pval;

  logic [VW-1:0] exp_q[$];
  localparam logic [VW-1:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 1'b0, W'(DEF)};

  function automatic logic [VW-1:0] model_vec();
    logic c, t;
    c = m_run && (m_pos < m_cur / 2);
    t = m_run && (m_pos == 0);
    return {c, t, ~m_pend, m_err, W'(m_cur)};
  endfunction

  task automatic model_edge();
    bit was_run;
    bit acc;
    if (i_rst) begin
      m_run = 0; m_pend = 0; m_err = 0; m_pos = 0; m_cur = DEF; m_pval = DEF;
    end else begin
      was_run = m_run;
      acc     = i_div_valid && !m_pend;
      m_err   = 0;
      if (!i_en) begin
        m_run = 0;
        m_pos = 0;
      end else if (!was_run) begin
        m_run = 1;
        m_pos = 0;
      end else if (m_pos == m_cur - 1) begin
        m_pos = 0;
        if (m_pend) begin
          m_cur  = m_pval;
          m_pend = 0;
        end
      end else begin
        m_pos = m_pos + 1;
      end
      if (!was_run && m_pend) begin
        m_cur  = m_pval;
        m_pend = 0;
      end
      if (acc) begin
        if (i_div >= 2) begin
          m_pend = 1;
          m_pval = int'(i_div);
        end else begin
          m_err = 1;
        end
      end
    end
    exp_q.push_back(model_vec());
  endtask

  // Advance one i_clk cycle: model the edge, then move to the sample point.
  task automatic step();
    @(posedge i_clk);
    model_edge();
    #6;
  endtask

  function automatic logic [VW-1:0] act_vec();
    return {o_clk, o_tick, o_div_ready, o_cfg_err, o_div_cur};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    logic [VW-1:0] e;
    i_rst = 1; i_en = 0; i_div = '0; i_div_valid = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== RESET_VEC) begin
        errors++;
        $display("FAIL reset: got %h want %h", act_vec(), RESET_VEC);
      end
    end
    checks++;
    if (e !== RESET_VEC) begin
      errors++;
      $display("FAIL reset_model: got %h want %h", e, RESET_VEC);
    end
  endtask

  task automatic test_default_run();
    logic [VW-1:0] e;
    i_rst = 0; i_en = 1;
    for (int i = 0; i < 12; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
        errors++;
        $display("FAIL default_run[%0d]: got %h want %h", i, act_vec(), e);
      end
      checks++;
      if ({o_clk, o_tick, o_div_cur} !== {(i % 2 == 0), (i % 2 == 0), W'(2)}) begin
        errors++;
        $display("FAIL default_pattern[%0d]: got clk=%b tick=%b cur=%0d", i, o_clk, o_tick, o_div_cur);
      end
    end
  endtask

  task automatic test_load5();
    logic [VW-1:0] e;
    int k;
    i_div = W'(5); i_div_valid = 1;
    step();
    i_div_valid = 0;
    e = exp_q.pop_front();
    checks++;
    if (act_vec() !== e || o_div_ready !== 1'b0) begin
      errors++;
      $display("FAIL load5_accept: got %h want %h", act_vec(), e);
    end
    k = -1;
    for (int i = 0; i < 25; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
        errors++;
        $display("FAIL load5_run[%0d]: got %h want %h", i, act_vec(), e);
      end
      if (k < 0 && o_div_cur == W'(5)) k = 0;
      if (k >= 0) begin
        checks++;
        if ({o_clk, o_div_ready} !== {((k % 5) < 2), 1'b1}) begin
          errors++;
          $display("FAIL load5_shape[%0d]: got clk=%b ready=%b want clk=%b ready=1", k, o_clk, o_div_ready, ((k % 5) < 2));
        end
        k++;
      end
    end
    checks++;
    if (k < 10) begin
      errors++;
      $display("FAIL load5_apply: got %0d samples at N=5 want at least 10", k);
    end
  endtask

  task automatic test_cfg_err();
    logic [VW-1:0] e;
    logic [W-1:0] bad [2];
    bad[0] = W'(1);
    bad[1] = W'(0);
    for (int b = 0; b < 2; b++) begin
      i_div = bad[b]; i_div_valid = 1;
      step();
      i_div_valid = 0;
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e || {o_cfg_err, o_div_ready, o_div_cur} !== {1'b1, 1'b1, W'(5)}) begin
        errors++;
        $display("FAIL cfg_err_pulse[%0d]: got %h want %h", b, act_vec(), e);
      end
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e || o_cfg_err !== 1'b0) begin
        errors++;
        $display("FAIL cfg_err_clear[%0d]: got %h want %h", b, act_vec(), e);
      end
    end
  endtask

  task automatic test_en_drop();
    logic [VW-1:0] e;
    int n;
    i_div = W'(8); i_div_valid = 1;
    step();
    i_div_valid = 0;
    void'(exp_q.pop_front());
    n = 0;
    while (o_div_cur !== W'(8) && n < 20) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
        errors++;
        $display("FAIL en_drop_wait[%0d]: got %h want %h", n, act_vec(), e);
      end
      n++;
    end
    checks++;
    if (o_div_cur !== W'(8)) begin
      errors++;
      $display("FAIL en_drop_apply: got cur=%0d want 8 within 20 cycles", o_div_cur);
    end
    step();
    void'(exp_q.pop_front());
    i_en = 0;
    step();
    e = exp_q.pop_front();
    checks++;
    if (act_vec() !== e || o_clk !== 1'b0) begin
      errors++;
      $display("FAIL en_drop_low: got %h want %h", act_vec(), e);
    end
    i_en = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e || {o_clk, o_tick} !== {(k < 4), (k == 0)}) begin
        errors++;
        $display("FAIL en_restart[%0d]: got %h want %h", k, act_vec(), e);
      end
    end
  endtask

  task automatic test_reset_pending();
    logic [VW-1:0] e;
    i_div = W'(6); i_div_valid = 1;
    step();
    i_div_valid = 0;
    e = exp_q.pop_front();
    checks++;
    if (act_vec() !== e || o_div_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_pend_accept: got %h want %h", act_vec(), e);
    end
    i_rst = 1;
    step();
    void'(exp_q.pop_front());
    checks++;
    if (act_vec() !== RESET_VEC) begin
      errors++;
      $display("FAIL rst_pend_reset: got %h want %h", act_vec(), RESET_VEC);
    end
    i_rst = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e || o_div_cur !== W'(DEF)) begin
        errors++;
        $display("FAIL rst_pend_lost[%0d]: got %h want %h", i, act_vec(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    for (int i = 0; i < 800; i++) begin
      i_rst       = ($urandom_range(0, 149) == 0);
      i_en        = ($urandom_range(0, 11) != 0);
      i_div_valid = ($urandom_range(0, 4) == 0);
      i_div       = W'($urandom_range(0, 9));
      step();
      e = exp_q.pop_front();
      checks++;
      if (act_vec() !== e) begin
        errors++;
        $display("FAIL random[%0d]: got %h want %h", i, act_vec(), e);
      end
    end
    i_rst = 0; i_div_valid = 0; i_en = 1;
  endtask

`ifdef CLK_DIV_ODD_50_EN
  task automatic test_odd50();
    realtime t0, t1, t2;
    int n;
    i_rst = 1; i_en = 0; i_div_valid = 0;
    step();
    i_rst = 0; i_div = W'(3); i_div_valid = 1;
    step();
    i_div_valid = 0; i_en = 1;
    repeat (4) step();
    exp_q.delete();
    checks++;
    if (o_div_cur !== W'(3)) begin
      errors++;
      $display("FAIL odd50_cur: got %0d want 3", o_div_cur);
    end
    // Poll on half-ns offsets so no sample lands on a clock edge.
    #0.5;
    n = 0;
    while (o_clk !== 1'b0 && n < 200) begin #1; n++; end
    while (o_clk !== 1'b1 && n < 200) begin #1; n++; end
    t0 = $realtime;
    while (o_clk !== 1'b0 && n < 200) begin #1; n++; end
    t1 = $realtime;
    while (o_clk !== 1'b1 && n < 200) begin #1; n++; end
    t2 = $realtime;
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL odd50_timeout: got no full o_clk period within 200 ns");
    end else if ((t1 - t0) != 15.0 || (t2 - t1) != 15.0) begin
      errors++;
      $display("FAIL odd50_duty: got high=%0t low=%0t want 15ns each", t1 - t0, t2 - t1);
    end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    i_rst = 1; i_en = 0; i_div = '0; i_div_valid = 0;
    test_reset();
    test_default_run();
    test_load5();
    test_cfg_err();
    test_en_drop();
    test_reset_pending();
    test_random();
`ifdef CLK_DIV_ODD_50_EN
    test_odd50();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
